// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the direct-mapped cache and its refill controller:
// default geometry, byte-address field offsets and the refill FSM state type.
// No ports (package).
// -----------------------------------------------------------------------------
package cache_pkg;

    // Default cache geometry.
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_SET_BITS   = 3;
    localparam int DEF_WORD_BITS  = 2;

    // Byte address layout: [tag | index | word | byte offset].
    localparam int BYTE_OFF_BITS  = 2;
    localparam int WORD_LSB       = BYTE_OFF_BITS;
    localparam int INDEX_LSB      = WORD_LSB + DEF_WORD_BITS;
    localparam int TAG_LSB        = INDEX_LSB + DEF_SET_BITS;
    localparam int TAG_W          = DEF_ADDR_WIDTH - TAG_LSB;
    localparam int LINE_WORDS     = 1 << DEF_WORD_BITS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2
    } refill_state_e;

endpackage

// File: rtl/cache_refill_ctrl_beat_ctr.sv
// -----------------------------------------------------------------------------
// refill_beat_ctr
// Beat sequencing for a line refill: a loadable word counter that wraps modulo
// the line size, plus a count of beats still outstanding with a last-beat flag.
//
// Ports:
//   clk, rst   clock, synchronous active-high reset (counters to 0)
//   load_i     start a new line: beat <- start_i, remaining <- line size
//   start_i    first word slot of the line
//   adv_i      one beat accepted: beat increments (wrapping), remaining drops
//   beat_o     current word slot
//   last_o     the current beat is the final one of the line
// -----------------------------------------------------------------------------
module refill_beat_ctr #(
    parameter int WORD_BITS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic [WORD_BITS-1:0] start_i,
    input  logic                 adv_i,
    output logic [WORD_BITS-1:0] beat_o,
    output logic                 last_o
);

    // One extra bit so the full line count (2^WORD_BITS) is representable.
    localparam int CNT_W = WORD_BITS + 1;
    localparam logic [CNT_W-1:0] LINE_BEATS = CNT_W'(1 << WORD_BITS);

    logic [WORD_BITS-1:0] beat_q, beat_d;
    logic [CNT_W-1:0]     left_q, left_d;

    always_comb begin
        beat_d = beat_q;
        left_d = left_q;
        if (load_i) begin
            beat_d = start_i;
            left_d = LINE_BEATS;
        end else if (adv_i) begin
            // Natural overflow of the WORD_BITS-wide sum gives the wrap.
            beat_d = beat_q + WORD_BITS'(1);
            left_d = left_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q <= '0;
            left_q <= '0;
        end else begin
            beat_q <= beat_d;
            left_q <= left_d;
        end
    end

    assign beat_o = beat_q;
    assign last_o = (left_q == CNT_W'(1));

endmodule

// File: rtl/cache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// cache_refill_ctrl
// Miss handler behind the direct-mapped cache. On a miss it stalls the CPU,
// reads the whole line from data memory one word per handshake, writes every
// word into the cache arrays, then pulses fill_done_o so the valid bit is set
// and the stalled access replays as a hit.
//
// Build option: define CACHE_CRITICAL_WORD_FIRST_EN to start the refill at the
// missing word (wrapping); otherwise the line is fetched from word 0 upward.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset (aborts a refill)
//   miss_i        cache lookup missed this cycle (sampled only in IDLE)
//   addr_i        byte address of the missing access
//   stall_o       hold the CPU pipeline
//   mem_req_o     memory read request
//   mem_addr_o    word-aligned memory read address
//   mem_valid_i   memory read data valid (ignored outside FETCH)
//   mem_rdata_i   memory read data
//   fill_we_o     cache array write enable
//   fill_index_o  set being filled
//   fill_word_o   word slot being written
//   fill_tag_o    tag written with the line
//   fill_data_o   word written
//   fill_done_o   line complete, set the valid bit
// -----------------------------------------------------------------------------
import cache_pkg::*;

module cache_refill_ctrl #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int SET_BITS   = DEF_SET_BITS,
    parameter int WORD_BITS  = DEF_WORD_BITS
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    miss_i,
    input  logic [ADDR_WIDTH-1:0]                   addr_i,
    output logic                                    stall_o,
    output logic                                    mem_req_o,
    output logic [ADDR_WIDTH-1:0]                   mem_addr_o,
    input  logic                                    mem_valid_i,
    input  logic [DATA_WIDTH-1:0]                   mem_rdata_i,
    output logic                                    fill_we_o,
    output logic [SET_BITS-1:0]                     fill_index_o,
    output logic [WORD_BITS-1:0]                    fill_word_o,
    output logic [ADDR_WIDTH-SET_BITS-WORD_BITS-3:0] fill_tag_o,
    output logic [DATA_WIDTH-1:0]                   fill_data_o,
    output logic                                    fill_done_o
);

    localparam int IDX_LSB       = WORD_LSB + WORD_BITS;
    localparam int TAG_FIELD_LSB = IDX_LSB + SET_BITS;
    localparam int LINE_TAG_W    = ADDR_WIDTH - TAG_FIELD_LSB;

    refill_state_e           state_q, state_d;
    logic [LINE_TAG_W-1:0]   tag_q, tag_d;
    logic [SET_BITS-1:0]     index_q, index_d;

    logic                    ctr_load;
    logic                    ctr_adv;
    logic [WORD_BITS-1:0]    start_word;
    logic [WORD_BITS-1:0]    beat;
    logic                    last_beat;

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
    assign start_word = addr_i[WORD_LSB +: WORD_BITS];
`else
    assign start_word = '0;
`endif

    // Byte offset never matters, and the word field is only consumed when the
    // critical word is fetched first.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_i[WORD_LSB +: WORD_BITS], addr_i[WORD_LSB-1:0]};

    refill_beat_ctr #(
        .WORD_BITS (WORD_BITS)
    ) u_beat_ctr (
        .clk     (clk),
        .rst     (rst),
        .load_i  (ctr_load),
        .start_i (start_word),
        .adv_i   (ctr_adv),
        .beat_o  (beat),
        .last_o  (last_beat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tag_q   <= '0;
            index_q <= '0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            index_q <= index_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        tag_d        = tag_q;
        index_d      = index_q;
        ctr_load     = 1'b0;
        ctr_adv      = 1'b0;
        stall_o      = 1'b0;
        mem_req_o    = 1'b0;
        mem_addr_o   = '0;
        fill_we_o    = 1'b0;
        fill_index_o = '0;
        fill_word_o  = '0;
        fill_tag_o   = '0;
        fill_data_o  = '0;
        fill_done_o  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Stall in the miss cycle itself so the CPU never advances.
                stall_o = miss_i;
                if (miss_i) begin
                    tag_d    = addr_i[TAG_FIELD_LSB +: LINE_TAG_W];
                    index_d  = addr_i[IDX_LSB +: SET_BITS];
                    ctr_load = 1'b1;
                    state_d  = ST_FETCH;
                end
            end

            ST_FETCH: begin
                stall_o      = 1'b1;
                mem_req_o    = 1'b1;
                mem_addr_o   = {tag_q, index_q, beat, {WORD_LSB{1'b0}}};
                fill_index_o = index_q;
                fill_tag_o   = tag_q;
                // Data passes straight through so zero-wait memory costs
                // exactly one cycle per beat.
                if (mem_valid_i) begin
                    fill_we_o   = 1'b1;
                    fill_data_o = mem_rdata_i;
                    fill_word_o = beat;
                    ctr_adv     = 1'b1;
                    if (last_beat) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                // Stall drops here: the replayed access hits this cycle.
                fill_done_o  = 1'b1;
                fill_index_o = index_q;
                fill_tag_o   = tag_q;
                state_d      = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
